// File: rtl/fsm_step_ctrl.sv
// Input conditioning for the switch-driven Mealy machines.
// Raw board switches and a step pushbutton are synchronised and debounced.
// The outputs are a clean 2-bit switch vector (sw_out) and a one-cycle
// step strobe (ctrl_out). An auto-step mode issues periodic strobes, and an
// 8-bit wrapping count of issued strobes is provided for display.
//
// Step FSM states:
//   state | meaning
//   IDLE  | waiting for a debounced button press or for auto mode
//   HELD  | press already turned into a request, waiting for release
//   AUTO  | periodic requests from the auto timer, button ignored
//
// Every output is driven straight from a flop.
module fsm_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 100,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  input  logic       btn_raw,
  input  logic       auto_en,
  output logic [1:0] sw_out,
  output logic       ctrl_out,
  output logic [7:0] step_count
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    AUTO = 2'd2
  } state_t;

  // Bit order in the synchroniser chain: {auto_en, btn, sw[1], sw[0]}
  logic [3:0]       sync_1;
  logic [3:0]       sync_2;
  logic [2:0]       deb;
  logic [CNT_W-1:0] db_cnt [3];

  state_t           state;
  logic [CNT_W-1:0] auto_tmr;
  logic             req;
  logic             req_sw_chg;
  logic             pending;

  logic [1:0]       deb_sw;
  logic             deb_btn;
  logic             auto_s;
  logic             sw_chg;

  assign deb_sw  = deb[1:0];
  assign deb_btn = deb[2];
  assign auto_s  = sync_2[3];
  // sw_out is about to take a new value on the coming edge.
  assign sw_chg  = (sw_out != deb_sw);

  // Two-flop synchronisers for every asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {auto_en, btn_raw, sw_raw};
      sync_2 <= sync_1;
    end
  end

  // Debounce sw[0], sw[1] and btn independently. A value is accepted only
  // after it has differed from the debounced value for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered copy of the debounced switch vector
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_out <= '0;
    end else begin
      sw_out <= deb_sw;
    end
  end

  // Step FSM: turns presses or auto-timer wraps into single-edge requests.
  // req_sw_chg remembers whether sw_out moved on the same edge as the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      auto_tmr   <= '0;
      req        <= 1'b0;
      req_sw_chg <= 1'b0;
    end else begin
      req        <= 1'b0;
      req_sw_chg <= sw_chg;
      case (state)
        IDLE: begin
          // Auto mode wins over a press seen on the same edge.
          if (auto_s) begin
            state    <= AUTO;
            auto_tmr <= '0;
          end else if (deb_btn) begin
            req   <= 1'b1;
            state <= HELD;
          end
        end
        HELD: begin
          if (auto_s) begin
            state    <= AUTO;
            auto_tmr <= '0;
          end else if (!deb_btn) begin
            state <= IDLE;
          end
        end
        AUTO: begin
          if (!auto_s) begin
            // Leaving auto with the button down must not look like a new press.
            state    <= deb_btn ? HELD : IDLE;
            auto_tmr <= '0;
          end else if (auto_tmr == AUTO_LAST) begin
            auto_tmr <= '0;
            req      <= 1'b1;
          end else begin
            auto_tmr <= auto_tmr + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          auto_tmr <= '0;
        end
      endcase
    end
  end

  // Strobe issue: a request whose edge also moved sw_out waits one extra
  // cycle in the pending flag; a request that meets a pending one is merged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_out   <= 1'b0;
      pending    <= 1'b0;
      step_count <= '0;
    end else begin
      ctrl_out <= 1'b0;
      if (ctrl_out) begin
        step_count <= step_count + 8'd1;
      end
      if (pending) begin
        ctrl_out <= 1'b1;
        pending  <= 1'b0;
      end else if (req) begin
        if (req_sw_chg) begin
          pending <= 1'b1;
        end else begin
          ctrl_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Scoreboard bench for fsm_step_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=10.
// A reference model is evaluated on every clock edge and pushes an expected
// strobe record when it decides a strobe is due. A monitor pops a record
// whenever the DUT raises ctrl_out. The run has directed phases followed by
// randomized stimulus.
module tb_fsm_step_ctrl;

  localparam int DB = 4;
  localparam int AP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic       btn_raw = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] sw_out;
  logic       ctrl_out;
  logic [7:0] step_count;

  fsm_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD(AP),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .btn_raw(btn_raw),
    .auto_en(auto_en),
    .sw_out(sw_out),
    .ctrl_out(ctrl_out),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 0;

  typedef struct {
    int         cyc;
    logic [1:0] sw;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         strobe_log[$];
  logic [1:0] strobe_sw_log[$];

  // Reference model state (values after the most recent edge)
  bit [3:0] m_dly1, m_dly2;
  bit [2:0] m_deb;
  int       m_run[3];
  bit [1:0] m_sw_out;
  int       m_cnt;
  bit       m_fired;
  bit       m_auto, m_hold;
  int       m_age;
  int       m_sched;
  bit       m_sched_def;

  // Reference model, one evaluation per clock edge
  always @(posedge clk) begin : model
    bit [3:0] seen;
    bit [1:0] deb_sw_old;
    bit       deb_btn_old, auto_old, sw_moving, want;
    int       cnt_new;
    cyc++;
    if (reset) begin
      m_dly1 = '0; m_dly2 = '0; m_deb = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_sw_out = '0; m_cnt = 0; m_fired = 0;
      m_auto = 0; m_hold = 0; m_age = 0;
      m_sched = -1; m_sched_def = 0;
    end else begin
      seen        = m_dly2;
      deb_sw_old  = m_deb[1:0];
      deb_btn_old = m_deb[2];
      auto_old    = seen[3];
      sw_moving   = (m_sw_out != deb_sw_old);
      cnt_new     = (m_cnt + (m_fired ? 1 : 0)) % 256;
      m_fired     = 0;
      if (m_sched == cyc) begin
        m_fired = 1;
        exp_q.push_back('{cyc, deb_sw_old, cnt_new[7:0]});
        m_sched = -1;
      end
      m_cnt = cnt_new;
      want = 0;
      if (m_auto) begin
        if (!auto_old) begin
          m_auto = 0;
          m_hold = deb_btn_old;
        end else begin
          m_age++;
          if (m_age % AP == 0) want = 1;
        end
      end else if (auto_old) begin
        m_auto = 1;
        m_age  = 0;
        m_hold = 0;
      end else if (m_hold) begin
        if (!deb_btn_old) m_hold = 0;
      end else if (deb_btn_old) begin
        want   = 1;
        m_hold = 1;
      end
      if (want && !(m_sched == cyc + 1 && m_sched_def)) begin
        m_sched     = cyc + 1 + (sw_moving ? 1 : 0);
        m_sched_def = sw_moving;
      end
      m_sw_out = deb_sw_old;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] == m_deb[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_deb[i] = seen[i];
            m_run[i] = 0;
          end
        end
      end
      m_dly2 = m_dly1;
      m_dly1 = {auto_en, btn_raw, sw_raw};
    end
  end

  // Monitor: compares DUT outputs against the model just after each edge
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (started) begin
      n_tests++;
      if (sw_out !== m_sw_out) begin
        n_fail++;
        $display("FAIL sw_out cyc=%0d got=%b exp=%b", cyc, sw_out, m_sw_out);
      end
      n_tests++;
      if (step_count !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL step_count cyc=%0d got=%0d exp=%0d", cyc, step_count, m_cnt);
      end
      if (ctrl_out === 1'b1) begin
        strobe_log.push_back(cyc);
        strobe_sw_log.push_back(sw_out);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.sw !== sw_out || e.cnt !== step_count) begin
            n_fail++;
            $display("FAIL strobe cyc=%0d sw=%b cnt=%0d exp_cyc=%0d exp_sw=%b exp_cnt=%0d",
                     cyc, sw_out, step_count, e.cyc, e.sw, e.cnt);
          end
        end
      end else if (ctrl_out !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ctrl_out_x cyc=%0d got=%b exp=0/1", cyc, ctrl_out);
      end else if (exp_q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_strobe cyc=%0d got=0 exp=1 exp_cyc=%0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin : stim
    int s0, press, lat, n;
    reset = 1'b1;
    tick(3);
    started = 1;
    check("reset_sw_out", int'(sw_out), 0);
    check("reset_ctrl_out", int'(ctrl_out), 0);
    check("reset_step_count", int'(step_count), 0);
    reset = 1'b0;
    tick(3);

    // 1: held press gives one strobe, D+3 edges after the first sampling edge
    s0 = strobe_log.size();
    btn_raw = 1'b1;
    press = cyc + 1;
    tick(20);
    check("t1_strobes", strobe_log.size() - s0, 1);
    lat = (strobe_log.size() > s0) ? strobe_log[s0] - press : -1;
    check("t1_latency", lat, DB + 3);
    check("t1_step_count", int'(step_count), 1);
    btn_raw = 1'b0;
    tick(12);

    // 2: short glitch is filtered; switch change alone gives no strobe
    do_reset();
    s0 = strobe_log.size();
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(12);
    check("t2_glitch_strobes", strobe_log.size() - s0, 0);
    check("t2_step_count", int'(step_count), 0);
    sw_raw = 2'b10;
    tick(6);
    check("t2_sw_before", int'(sw_out), 0);
    tick(1);
    check("t2_sw_after", int'(sw_out), 2);
    tick(10);
    check("t2_sw_strobes", strobe_log.size() - s0, 0);

    // 3: switch and button change together -> strobe deferred one cycle
    s0 = strobe_log.size();
    sw_raw = 2'b01;
    btn_raw = 1'b1;
    press = cyc + 1;
    tick(6);
    check("t3_sw_old", int'(sw_out), 2);
    tick(1);
    check("t3_sw_new", int'(sw_out), 1);
    tick(13);
    check("t3_strobes", strobe_log.size() - s0, 1);
    lat = (strobe_log.size() > s0) ? strobe_log[s0] - press : -1;
    check("t3_latency", lat, DB + 4);
    lat = (strobe_sw_log.size() > s0) ? int'(strobe_sw_log[s0]) : -1;
    check("t3_strobe_sw", lat, 1);
    btn_raw = 1'b0;
    tick(12);

    // 4: auto mode with button held, then release of auto while held
    btn_raw = 1'b1;
    tick(12);
    s0 = strobe_log.size();
    auto_en = 1'b1;
    press = cyc + 1;
    tick(45);
    auto_en = 1'b0;
    tick(5);
    check("t4_auto_strobes", strobe_log.size() - s0, 4);
    lat = (strobe_log.size() > s0) ? strobe_log[s0] - press : -1;
    check("t4_first_auto", lat, AP + 3);
    for (int k = 1; k < 4; k++) begin
      lat = (strobe_log.size() > s0 + k) ? strobe_log[s0 + k] - strobe_log[s0 + k - 1] : -1;
      check("t4_spacing", lat, AP);
    end
    s0 = strobe_log.size();
    tick(20);
    check("t4_held_no_strobe", strobe_log.size() - s0, 0);
    btn_raw = 1'b0;
    tick(12);
    btn_raw = 1'b1;
    tick(12);
    check("t4_repress", strobe_log.size() - s0, 1);
    btn_raw = 1'b0;
    tick(12);

    // 5: presses until step_count wraps to 0, then reset mid-press
    n = (256 - m_cnt) % 256;
    if (n == 0) n = 256;
    s0 = strobe_log.size();
    for (int k = 0; k < n; k++) begin
      btn_raw = 1'b1;
      tick(9);
      btn_raw = 1'b0;
      tick(8);
    end
    tick(4);
    check("t5_presses", strobe_log.size() - s0, n);
    check("t5_wrap", int'(step_count), 0);
    s0 = strobe_log.size();
    btn_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    btn_raw = 1'b0;
    tick(1);
    check("t5_rst_sw", int'(sw_out), 0);
    check("t5_rst_ctrl", int'(ctrl_out), 0);
    check("t5_rst_cnt", int'(step_count), 0);
    reset = 1'b0;
    tick(20);
    check("t5_no_strobe", strobe_log.size() - s0, 0);

    // Randomized phase against the reference model
    for (int i = 0; i < 3000; i++) begin
      int b;
      if ($urandom_range(0, 5) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 9) == 0) begin
        b = int'($urandom_range(0, 1));
        sw_raw[b] = ~sw_raw[b];
      end
      if ($urandom_range(0, 79) == 0) auto_en = ~auto_en;
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0;
    auto_en = 1'b0;
    btn_raw = 1'b0;
    tick(30);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
